gray_seq_ctrl: RTL and testbench

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

---
 rtl/gray_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_gray_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gray_seq_ctrl: runs a 3-bit gray counter for N enables and checks   |
// | that it steps one bit per enable. Rev 1.0                            |
// +--------------------------------------------------------------------+
module gray_seq_ctrl (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Steps,
  input  logic       Pause,
  input  logic       Abort,
  input  logic [2:0] Gray_In,
  input  logic       Ovf_In,
  output logic       Cnt_En,
  output logic       Cnt_Clr,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] Wraps,
  output logic [2:0] Last_Gray,
  output logic       Err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [3:0] wraps_q, wraps_d;
  logic [2:0] last_gray_q, last_gray_d;
  logic       err_q, err_d;

  logic       ovf_prev_q;
  logic       en_prev_q;
  logic       clr_prev_q;
  logic [2:0] gray_prev_q;

  logic [2:0] gray_diff;
  logic       one_bit_step;
  logic       gray_bad;
  logic       ovf_rise;

  assign Cnt_Clr   = (state_q == S_CLEAR);
  assign Busy      = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign Done      = (state_q == S_DONE);
  assign Cnt_En    = (state_q == S_RUN) && !Pause && (remaining_q != 8'd0);
  assign Wraps     = wraps_q;
  assign Last_Gray = last_gray_q;
  assign Err       = err_q;

  // A legal step flips exactly one bit; with no enable and no clear nothing may move.
  assign gray_diff    = Gray_In ^ gray_prev_q;
  assign one_bit_step = (gray_diff != 3'd0) && ((gray_diff & (gray_diff - 3'd1)) == 3'd0);
  assign gray_bad     = !clr_prev_q &&
                        ((en_prev_q && !one_bit_step) || (!en_prev_q && (gray_diff != 3'd0)));
  assign ovf_rise     = Ovf_In && !ovf_prev_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wraps_d     = wraps_q;
    last_gray_d = last_gray_q;
    err_d       = err_q;

    if (Busy && ovf_rise && (wraps_q != 4'hf)) begin
      wraps_d = wraps_q + 4'd1;
    end
    if (((state_q == S_RUN) || (state_q == S_DRAIN)) && gray_bad) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (Start && !Abort) begin
          state_d     = S_CLEAR;
          remaining_d = Steps;
          wraps_d     = 4'd0;
          err_d       = 1'b0;
        end
      end
      S_CLEAR: begin
        if (Abort) begin
          state_d     = S_IDLE;
          remaining_d = 8'd0;
        end else if (remaining_q != 8'd0) begin
          state_d = S_RUN;
        end else begin
          state_d     = S_DONE;
          last_gray_d = Gray_In;
        end
      end
      S_RUN: begin
        if (Abort) begin
          state_d     = S_IDLE;
          remaining_d = 8'd0;
        end else if (Cnt_En) begin
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (Abort) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_DONE;
          last_gray_d = Gray_In;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: begin
        state_d     = S_IDLE;
        remaining_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      remaining_q <= 8'd0;
      wraps_q     <= 4'd0;
      last_gray_q <= 3'b000;
      err_q       <= 1'b0;
      ovf_prev_q  <= 1'b0;
      en_prev_q   <= 1'b0;
      clr_prev_q  <= 1'b0;
      gray_prev_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wraps_q     <= wraps_d;
      last_gray_q <= last_gray_d;
      err_q       <= err_d;
      ovf_prev_q  <= Ovf_In;
      en_prev_q   <= Cnt_En;
      clr_prev_q  <= Cnt_Clr;
      gray_prev_q <= Gray_In;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gray_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gray_seq_ctrl: directed bench with a gray counter model and a    |
// | scoreboard of expected run results. Rev 1.0                          |
// +--------------------------------------------------------------------+
module tb_gray_seq_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] Steps = 8'd0;
  logic       Pause = 1'b0;
  logic       Abort = 1'b0;
  logic [2:0] Gray_In;
  logic       Ovf_In;
  logic       Cnt_En, Cnt_Clr, Busy, Done, Err;
  logic [3:0] Wraps;
  logic [2:0] Last_Gray;

  gray_seq_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Steps(Steps), .Pause(Pause),
    .Abort(Abort), .Gray_In(Gray_In), .Ovf_In(Ovf_In), .Cnt_En(Cnt_En),
    .Cnt_Clr(Cnt_Clr), .Busy(Busy), .Done(Done), .Wraps(Wraps),
    .Last_Gray(Last_Gray), .Err(Err)
  );

  always #5 Clk = ~Clk;

  // Controlled counter: sync clear, step on enable, overflow pulse after 7->0.
  logic [2:0] bin_q;
  logic       ovf_q;
  bit         glitch_arm = 1'b0;
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bin_q <= 3'd0;
      ovf_q <= 1'b0;
    end else if (Cnt_Clr) begin
      bin_q <= 3'd0;
      ovf_q <= 1'b0;
    end else if (Cnt_En) begin
      bin_q <= bin_q + ((glitch_arm && bin_q == 3'd0) ? 3'd2 : 3'd1);
      ovf_q <= (bin_q == 3'd7);
    end else begin
      ovf_q <= 1'b0;
    end
  end
  assign Gray_In = bin_q ^ (bin_q >> 1);
  assign Ovf_In  = ovf_q;

  int en_cnt = 0, clr_cnt = 0, busy_cnt = 0, done_cnt = 0;
  always @(posedge Clk) begin
    en_cnt   <= en_cnt   + (Cnt_En  ? 1 : 0);
    clr_cnt  <= clr_cnt  + (Cnt_Clr ? 1 : 0);
    busy_cnt <= busy_cnt + (Busy    ? 1 : 0);
    done_cnt <= done_cnt + (Done    ? 1 : 0);
  end

  typedef struct {
    logic [2:0] lg;
    logic [3:0] wr;
    logic       er;
    int         en;
    int         busy;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int en0, clr0, busy0, done0;
  logic [2:0] prev_lg = 3'b000;

  function automatic logic [2:0] g(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] wraps_of(input int s);
    return (s / 8 > 15) ? 4'd15 : 4'(s / 8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] lg, input logic [3:0] wr, input logic er,
                          input int en, input int busy);
    exp_t e;
    e.lg = lg; e.wr = wr; e.er = er; e.en = en; e.busy = busy;
    sb.push_back(e);
    prev_lg = lg;
  endtask

  task automatic start_run(input logic [7:0] s, input bit hold);
    Start = 1'b1;
    Steps = s;
    tick();
    if (!hold) Start = 1'b0;
    Steps = 8'($urandom);
    en0 = en_cnt; clr0 = clr_cnt; busy0 = busy_cnt; done0 = done_cnt;
    chk("clear_clr", 32'(Cnt_Clr), 32'd1);
    chk("clear_en",  32'(Cnt_En),  32'd0);
    chk("clear_busy", 32'(Busy),   32'd1);
    chk("clear_err", 32'(Err),     32'd0);
  endtask

  task automatic finish_run(input int bound);
    exp_t e;
    int n = 0;
    while (Done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    Start = 1'b0;
    chk("done_seen", 32'(Done), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("last_gray", 32'(Last_Gray), 32'(e.lg));
      chk("wraps",     32'(Wraps),     32'(e.wr));
      chk("err",       32'(Err),       32'(e.er));
      chk("done_busy", 32'(Busy),      32'd0);
      chk("en_total",  32'(en_cnt - en0),     32'(e.en));
      chk("clr_total", 32'(clr_cnt - clr0),   32'd1);
      chk("busy_len",  32'(busy_cnt - busy0), 32'(e.busy));
    end
    tick();
    chk("done_pulse", 32'(Done), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},   32'(Cnt_En),    32'd0);
    chk({tag, "_clr"},  32'(Cnt_Clr),   32'd0);
    chk({tag, "_busy"}, 32'(Busy),      32'd0);
    chk({tag, "_done"}, 32'(Done),      32'd0);
    chk({tag, "_wr"},   32'(Wraps),     32'd0);
    chk({tag, "_lg"},   32'(Last_Gray), 32'd0);
    chk({tag, "_err"},  32'(Err),       32'd0);
  endtask

  initial begin
    #2;
    chk_all_zero("rst");
    Reset = 1'b0;
    tick();

    // Basic run, single wrap, saturated wraps.
    push_exp(g(3'd5), 4'd0, 1'b0, 5, 7);
    start_run(8'd5, 1'b0);
    finish_run(40);

    push_exp(g(3'd0), wraps_of(8), 1'b0, 8, 10);
    start_run(8'd8, 1'b0);
    finish_run(40);

    push_exp(g(3'(200 % 8)), wraps_of(200), 1'b0, 200, 202);
    start_run(8'd200, 1'b0);
    finish_run(260);

    // Pause for three cycles after the second enable.
    push_exp(g(3'd4), 4'd0, 1'b0, 4, 9);
    start_run(8'd4, 1'b0);
    tick();
    tick();
    tick();
    Pause = 1'b1;
    #1;
    chk("pause_en", 32'(Cnt_En), 32'd0);
    tick();
    tick();
    chk("pause_busy", 32'(Busy), 32'd1);
    tick();
    Pause = 1'b0;
    finish_run(40);

    // Abort after two enables.
    start_run(8'd6, 1'b0);
    tick();
    tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abort_en",   32'(Cnt_En),    32'd0);
    chk("abort_busy", 32'(Busy),      32'd0);
    chk("abort_lg",   32'(Last_Gray), 32'(prev_lg));
    tick();
    tick();
    chk("abort_nodone", 32'(done_cnt - done0), 32'd0);
    chk("abort_steps",  32'(en_cnt - en0),     32'd2);

    // Zero steps: Last_Gray takes whatever the counter shows during CLEAR.
    push_exp(g(bin_q), 4'd0, 1'b0, 0, 1);
    start_run(8'd0, 1'b0);
    finish_run(10);

    // Injected two-bit jump on the first step.
    glitch_arm = 1'b1;
    push_exp(g(3'd4), 4'd0, 1'b1, 3, 5);
    start_run(8'd3, 1'b0);
    finish_run(20);
    glitch_arm = 1'b0;
    tick();
    tick();
    chk("err_sticky_idle", 32'(Err), 32'd1);

    push_exp(g(3'd5), 4'd0, 1'b0, 5, 7);
    start_run(8'd5, 1'b0);
    finish_run(40);

    // Asynchronous reset between edges mid-run.
    start_run(8'd10, 1'b0);
    tick();
    tick();
    tick();
    #3;
    Reset = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    #1;
    Reset = 1'b0;
    tick();
    chk("post_rst_busy", 32'(Busy), 32'd0);
    tick();
    tick();
    chk("post_rst_nodone", 32'(done_cnt - done0), 32'd0);

    // Start held through the whole run must not launch a second run.
    push_exp(g(3'd5), 4'd0, 1'b0, 5, 7);
    start_run(8'd5, 1'b1);
    finish_run(40);
    tick();
    tick();
    chk("held_start_idle", 32'(Busy), 32'd0);
    chk("held_start_clr",  32'(clr_cnt - clr0), 32'd1);

    // Abort together with Start in IDLE.
    Start = 1'b1;
    Abort = 1'b1;
    Steps = 8'd3;
    tick();
    Start = 1'b0;
    Abort = 1'b0;
    chk("abort_start_busy", 32'(Busy),    32'd0);
    chk("abort_start_clr",  32'(Cnt_Clr), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
